// File: rtl/jtag_ram_dr.sv
// JTAG user data register giving a host scan access to a small word array.
// Frame is {op, addr, data}, shifted LSB first. Capture returns
// {wrap, last_wr, ptr, rdata_q}. Fabric logic gets a registered read port.
// Everything runs in the TCK domain with a synchronous active-low reset.
module jtag_ram_dr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              i_tck,
  input  logic              i_reset_n,
  input  logic              i_sel,
  input  logic              i_capture,
  input  logic              i_shift,
  input  logic              i_update,
  input  logic              i_tdi,
  output logic              o_tdo,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_fab_addr,
  output logic [DATA_W-1:0] o_fab_data
);

  localparam int W     = 2 + ADDR_W + DATA_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {OpNop, OpLoad, OpWrite, OpRead} op_e;

  logic [W-1:0]      r_sr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_last_wr;
  logic              r_wrap;
  logic [DATA_W-1:0] r_fab_data;

  op_e               w_op;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_capture;
  logic              w_update;
  logic              w_shift;
  logic              w_wr_en;
  logic              w_ptr_step;

  // Strobe decode: capture beats update beats shift, all gated by SEL.
  always_comb begin
    w_op       = op_e'(r_sr[W-1:W-2]);
    w_addr     = r_sr[W-3:DATA_W];
    w_data     = r_sr[DATA_W-1:0];
    w_capture  = i_sel & i_capture;
    w_update   = i_sel & i_update & ~i_capture;
    w_shift    = i_sel & i_shift & ~i_capture & ~i_update;
    w_wr_en    = w_update && (w_op == OpWrite);
    w_ptr_step = w_update && i_inc && ((w_op == OpWrite) || (w_op == OpRead));
    o_tdo      = i_sel & r_sr[0];
    o_fab_data = r_fab_data;
  end

  // Scan register: parallel load on capture, right shift with TDI into the MSB.
  always_ff @(posedge i_tck) begin
    if (!i_reset_n) begin
      r_sr <= '0;
    end else if (w_capture) begin
      r_sr <= {r_wrap, r_last_wr, r_ptr, r_rdata};
    end else if (w_shift) begin
      r_sr <= {i_tdi, r_sr[W-1:1]};
    end
  end

  // Pointer, read data and status flags; wrap is sticky until the next capture.
  always_ff @(posedge i_tck) begin
    if (!i_reset_n) begin
      r_ptr     <= '0;
      r_rdata   <= '0;
      r_last_wr <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (w_capture) begin
      r_wrap <= 1'b0;
    end else if (w_update) begin
      case (w_op)
        OpNop: ;
        OpLoad: begin
          r_ptr     <= w_addr;
          r_rdata   <= r_mem[w_addr];
          r_last_wr <= 1'b0;
        end
        OpWrite: r_last_wr <= 1'b1;
        OpRead: begin
          r_rdata   <= r_mem[r_ptr];
          r_last_wr <= 1'b0;
        end
      endcase
      if (w_ptr_step) begin
        r_ptr <= r_ptr + ADDR_W'(1);
        if (r_ptr == {ADDR_W{1'b1}}) r_wrap <= 1'b1;
      end
    end
  end

  // Word array, written only by a WRITE update at the pointer.
  always_ff @(posedge i_tck) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_ptr] <= w_data;
    end
  end

  // Fabric read port; a same-edge write is seen one cycle later.
  always_ff @(posedge i_tck) begin
    if (!i_reset_n) begin
      r_fab_data <= '0;
    end else begin
      r_fab_data <= r_mem[i_fab_addr];
    end
  end

endmodule

// File: tb/tb_jtag_ram_dr.sv
// Directed bench for jtag_ram_dr with DATA_W=32, ADDR_W=4 (38-bit frame).
module tb_jtag_ram_dr;

  logic        clk = 1'b0;
  logic        rst_n, sel, capture, shift, update, tdi, tdo, inc;
  logic [3:0]  fab_addr;
  logic [31:0] fab_data;
  logic [37:0] d;
  int          n_checks = 0;
  int          n_fail   = 0;

  jtag_ram_dr #(.DATA_W(32), .ADDR_W(4)) dut (
    .i_tck      (clk),
    .i_reset_n  (rst_n),
    .i_sel      (sel),
    .i_capture  (capture),
    .i_shift    (shift),
    .i_update   (update),
    .i_tdi      (tdi),
    .o_tdo      (tdo),
    .i_inc      (inc),
    .i_fab_addr (fab_addr),
    .o_fab_data (fab_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] frm(input logic [1:0] op, input logic [3:0] a,
                                      input logic [31:0] dat);
    return {op, a, dat};
  endfunction

  // Shift n bits of din in LSB first, collecting TDO before each edge.
  task automatic shift_bits(input logic [37:0] din, input int n, output logic [37:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tdi     = din[i];
      shift   = 1'b1;
      tick();
    end
    shift = 1'b0;
    tdi   = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic do_capture();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0;
    tdi = 1'b0; inc = 1'b0; fab_addr = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    sel   = 1'b1;
    #1;
    check("reset_tdo", 64'(tdo), 64'd0);
    check("reset_fab", 64'(fab_data), 64'd0);
    do_capture();
    shift_bits('0, 38, d);
    check("reset_frame", 64'(d), 64'd0);

    // LOAD 3, WRITE DEADBEEF with increment
    shift_bits(frm(2'b01, 4'd3, 32'h0), 38, d);
    do_update();
    inc = 1'b1;
    shift_bits(frm(2'b10, 4'd0, 32'hDEADBEEF), 38, d);
    do_update();
    inc = 1'b0;
    do_capture();
    shift_bits('0, 38, d);
    check("write_frame", 64'(d), 64'({2'b01, 4'h4, 32'h0}));
    fab_addr = 4'd3;
    tick();
    check("fab_read3", 64'(fab_data), 64'hDEADBEEF);

    // Fabric read of the word being written returns the old value first
    fab_addr = 4'd4;
    shift_bits(frm(2'b10, 4'd0, 32'hA5), 38, d);
    do_update();
    check("fab_old", 64'(fab_data), 64'd0);
    tick();
    check("fab_new", 64'(fab_data), 64'hA5);

    // Readback through the scan chain
    shift_bits(frm(2'b01, 4'd3, 32'h0), 38, d);
    do_update();
    do_capture();
    shift_bits('0, 38, d);
    check("rb_data", 64'(d[31:0]), 64'hDEADBEEF);
    check("rb_addr", 64'(d[35:32]), 64'd3);
    check("rb_lastwr", 64'(d[36]), 64'd0);

    // Pointer wrap 15 -> 0
    shift_bits(frm(2'b01, 4'd15, 32'h0), 38, d);
    do_update();
    inc = 1'b1;
    shift_bits(frm(2'b11, 4'd0, 32'h0), 38, d);
    do_update();
    inc = 1'b0;
    do_capture();
    shift_bits('0, 38, d);
    check("wrap_set", 64'(d[37]), 64'd1);
    check("wrap_ptr", 64'(d[35:32]), 64'd0);
    do_capture();
    shift_bits('0, 38, d);
    check("wrap_clr", 64'(d[37]), 64'd0);

    // Two writes without increment
    shift_bits(frm(2'b01, 4'd7, 32'h0), 38, d);
    do_update();
    shift_bits(frm(2'b10, 4'd0, 32'h11), 38, d);
    do_update();
    shift_bits(frm(2'b10, 4'd0, 32'h22), 38, d);
    do_update();
    do_capture();
    shift_bits('0, 38, d);
    check("noinc_frame", 64'(d), 64'({2'b01, 4'h7, 32'h0}));
    fab_addr = 4'd7;
    tick();
    check("noinc_mem7", 64'(fab_data), 64'h22);

    // SEL low: strobes ignored, TDO forced low
    shift_bits(frm(2'b10, 4'd0, 32'h33), 38, d);
    sel = 1'b0;
    tdi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      capture = (i % 3 == 0);
      shift   = (i % 3 == 1);
      update  = (i % 3 == 2);
      tick();
      check("selo_tdo", 64'(tdo), 64'd0);
    end
    capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
    sel = 1'b1;
    tick();
    check("selo_mem", 64'(fab_data), 64'h22);
    check("selo_sr0", 64'(tdo), 64'd1);
    do_update();
    tick();
    check("selo_held", 64'(fab_data), 64'h33);
    do_capture();
    shift_bits('0, 38, d);
    check("selo_frame", 64'(d), 64'({2'b01, 4'h7, 32'h0}));

    // CAPTURE and UPDATE together: capture wins
    shift_bits(frm(2'b10, 4'd0, 32'h44), 38, d);
    capture = 1'b1;
    update  = 1'b1;
    tick();
    capture = 1'b0;
    update  = 1'b0;
    tick();
    check("cu_mem", 64'(fab_data), 64'h33);
    shift_bits('0, 38, d);
    check("cu_frame", 64'(d), 64'({2'b01, 4'h7, 32'h0}));

    // Reset mid-shift, then UPDATE decodes NOP
    inc = 1'b1;
    shift_bits({38{1'b1}}, 20, d);
    rst_n = 1'b0;
    shift = 1'b1;
    tdi   = 1'b1;
    tick();
    rst_n = 1'b1;
    shift = 1'b0;
    tdi   = 1'b0;
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_fab", 64'(fab_data), 64'd0);
    do_update();
    do_capture();
    shift_bits('0, 38, d);
    check("rst_nop_frame", 64'(d), 64'd0);
    tick();
    check("rst_mem7", 64'(fab_data), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_ram_dr.md
# jtag_ram_dr

User-data-register scan port giving a JTAG host read/write access to a parametrised on-chip word array. It generalises the fixed-width scan ROM:
- the scan frame carries an opcode, an address and a data word;
- the address pointer can auto-increment and reports wrap-around;
- contents are also readable by fabric logic through a registered port.

It sits directly behind the BSCAN user-register strobes (SEL/CAPTURE/SHIFT/UPDATE) and runs entirely in the TCK domain.

## Interface
- DATA_W, 32, data word width (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- W (derived, not overridable) = 2 + ADDR_W + DATA_W, scan register length

Ports:
- TCK  in  1  sole clock; all state changes on rising edge
- RESET_N  in  1  reset; synchronous and active-low
- SEL  in  1  user register selected; when low CAPTURE/SHIFT/UPDATE are ignored
- CAPTURE  in  1  Capture-DR strobe
- SHIFT  in  1  Shift-DR strobe
- UPDATE  in  1  Update-DR strobe
- TDI  in  1  serial data in
- TDO  out  1  serial data out = sr[0] when SEL, else 0 (combinational)
- INC  in  1  auto-increment pointer after WRITE/READ ops
- FAB_ADDR  in  ADDR_W  fabric read address
- FAB_DATA  out  DATA_W  registered fabric read data

## Operation
Internal state:
- sr[W-1:0], the scan register;
- mem[DEPTH], a flop array;
- ptr[ADDR_W-1:0], the address pointer;
- rdata_q[DATA_W-1:0], the read data register;
- last_wr, a 1-bit flag;
- wrap, a 1-bit sticky flag.

Frame layout:
- sr[W-1:W-2] = op;
- sr[W-3:DATA_W] = addr;
- sr[DATA_W-1:0] = data.

Action per edge with SEL high. Priority is CAPTURE > UPDATE > SHIFT; exactly one action per edge.
- CAPTURE: sr <= {wrap, last_wr, ptr, rdata_q}; wrap <= 0 on the same edge.
- SHIFT: sr <= {TDI, sr[W-1:1]}. Bits shift LSB first; TDI enters the MSB.
- UPDATE: decode op from the current sr:
  - 00 NOP: no state change.
  - 01 LOAD: ptr <= addr; rdata_q <= mem[addr]; last_wr <= 0.
  - 10 WRITE: mem[ptr] <= data; last_wr <= 1; if INC, ptr <= ptr+1.
  - 11 READ: rdata_q <= mem[ptr]; last_wr <= 0; if INC, ptr <= ptr+1.
- Pointer increment is modulo DEPTH. An increment from DEPTH-1 to 0 sets wrap. wrap stays set until the next CAPTURE.
- With SEL low, sr, ptr, mem, rdata_q and the flags all hold.
- Fabric port:
  - FAB_DATA <= mem[FAB_ADDR] every cycle, independent of SEL.
  - A fabric read of the address being written on the same edge returns the old value; the new value appears one cycle later.

## Timing
- Reset, on a TCK edge with RESET_N=0:
  - sr, ptr, rdata_q, last_wr, wrap and FAB_DATA all go to 0;
  - every mem word goes to 0;
  - TDO = 0.
  - Reset overrides any strobe on the same edge.
- Reset mid-shift aborts the frame. The next UPDATE without a fresh full shift decodes op=00 (NOP).
- TDO changes after each SHIFT/CAPTURE edge. The host samples it on the falling edge.
- UPDATE→CAPTURE latency: rdata_q is valid one edge after UPDATE. Since a TAP needs ≥2 TCK edges from Update-DR to Capture-DR, the read data is always captured.
- FAB_DATA latency: 1 TCK.
- A partial shift (fewer than W bits) leaves stale upper bits in sr. UPDATE acts on whatever sr holds; this is not an error.

## Test plan
- Reset with RESET_N=0 for 3 edges, then SEL=1, CAPTURE, shift out 38 bits (DATA_W=32, ADDR_W=4) → all zeros on TDO; FAB_DATA=0.
- Write sequence: LOAD addr=3; then WRITE 0xDEADBEEF with INC=1 → ptr=4, last_wr=1. A subsequent CAPTURE yields frame {0,1,4'h4,rdata_q}. Then FAB_ADDR=3 gives FAB_DATA=0xDEADBEEF one cycle later.
- Readback: LOAD addr=3, CAPTURE, shift 38 bits → low 32 bits read LSB first = 0xDEADBEEF; addr field = 3.
- Wrap: LOAD addr=15, READ with INC=1 → ptr=0. The next CAPTURE shows wrap=1; the CAPTURE after that shows wrap=0.
- INC=0: two consecutive WRITEs (0x11, then 0x22) at ptr=7 → ptr stays 7; mem[7]=0x22.
- Strobe handling:
  - SEL=0 with CAPTURE/SHIFT/UPDATE toggling → no state change; TDO=0.
  - CAPTURE and UPDATE together → capture only; mem unchanged.
  - Reset asserted mid-shift, then UPDATE → NOP.
